// File: rtl/ifid_buffer.sv
// IF/ID pipeline register: carries the incremented PC and fetched instruction
// from fetch to decode, with stall (hold) and flush (squash to NOP) control.
module ifid_buffer #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] FLUSH_INST = '0,
    parameter logic [WIDTH-1:0] FLUSH_PC   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             IFID_enable,
    input  logic [WIDTH-1:0] pcAddIn,
    input  logic [WIDTH-1:0] instIn,
    output logic [WIDTH-1:0] pcAddOut,
    output logic [WIDTH-1:0] instOut
);

    logic [WIDTH-1:0] pcAddReg;
    logic [WIDTH-1:0] instReg;

    // PC and instruction share one priority chain so they always move as a pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcAddReg <= FLUSH_PC;
            instReg  <= FLUSH_INST;
        end else if (flush) begin
            pcAddReg <= FLUSH_PC;
            instReg  <= FLUSH_INST;
        end else if (IFID_enable) begin
            pcAddReg <= pcAddIn;
            instReg  <= instIn;
        end
    end

    assign pcAddOut = pcAddReg;
    assign instOut  = instReg;

endmodule

// File: tb/tb_ifid_buffer.sv
// Directed self-checking bench for ifid_buffer: reset, load, stall, flush,
// synchronous reset timing, recovery and back-to-back updates.
module tb_ifid_buffer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             IFID_enable;
    logic [WIDTH-1:0] pcAddIn;
    logic [WIDTH-1:0] instIn;
    logic [WIDTH-1:0] pcAddOut;
    logic [WIDTH-1:0] instOut;

    int testsRun    = 0;
    int testsFailed = 0;

    ifid_buffer #(
        .WIDTH      (WIDTH),
        .FLUSH_INST (16'h0000),
        .FLUSH_PC   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .IFID_enable (IFID_enable),
        .pcAddIn     (pcAddIn),
        .instIn      (instIn),
        .pcAddOut    (pcAddOut),
        .instOut     (instOut)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge, well away from the active edge.
    task automatic drive(input logic r, input logic f, input logic e,
                         input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] i);
        @(negedge clk);
        rst_n       = r;
        flush       = f;
        IFID_enable = e;
        pcAddIn     = p;
        instIn      = i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 16'hABCD);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0000 || instOut !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset: got pc=%h inst=%h, expected pc=0000 inst=0000", pcAddOut, instOut);
        end
        $display("[TB] reset      pc=%h inst=%h", pcAddOut, instOut);
        drive(1'b0, 1'b1, 1'b1, 16'h5555, 16'h7777);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0000 || instOut !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_over_flush_enable: got pc=%h inst=%h, expected pc=0000 inst=0000", pcAddOut, instOut);
        end
        $display("[TB] reset+fl   pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_load();
        drive(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0001);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0002 || instOut !== 16'h0001) begin
            testsFailed++;
            $display("[TB] FAIL load1: got pc=%h inst=%h, expected pc=0002 inst=0001", pcAddOut, instOut);
        end
        $display("[TB] load1      pc=%h inst=%h", pcAddOut, instOut);
        drive(1'b1, 1'b0, 1'b1, 16'h0004, 16'h0002);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0004 || instOut !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL load2: got pc=%h inst=%h, expected pc=0004 inst=0002", pcAddOut, instOut);
        end
        $display("[TB] load2      pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 16'h0006, 16'h0003);
        for (int k = 0; k < 3; k++) begin
            tick();
            testsRun++;
            if (pcAddOut !== 16'h0004 || instOut !== 16'h0002) begin
                testsFailed++;
                $display("[TB] FAIL stall%0d: got pc=%h inst=%h, expected pc=0004 inst=0002", k, pcAddOut, instOut);
            end
            $display("[TB] stall%0d     pc=%h inst=%h", k, pcAddOut, instOut);
        end
    endtask

    task automatic test_input_glitch();
        // Inputs toggled between edges must not reach the outputs.
        @(posedge clk);
        #2;
        IFID_enable = 1'b1;
        pcAddIn     = 16'hDEAD;
        instIn      = 16'hBEEF;
        #1;
        IFID_enable = 1'b0;
        #1;
        testsRun++;
        if (pcAddOut !== 16'h0004 || instOut !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL input_glitch: got pc=%h inst=%h, expected pc=0004 inst=0002", pcAddOut, instOut);
        end
        $display("[TB] glitch     pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b1, 16'h0008, 16'h0001);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0000 || instOut !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL flush_enable: got pc=%h inst=%h, expected pc=0000 inst=0000", pcAddOut, instOut);
        end
        $display("[TB] flush_en   pc=%h inst=%h", pcAddOut, instOut);
        drive(1'b1, 1'b0, 1'b1, 16'h000A, 16'h0005);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h000A || instOut !== 16'h0005) begin
            testsFailed++;
            $display("[TB] FAIL reload: got pc=%h inst=%h, expected pc=000a inst=0005", pcAddOut, instOut);
        end
        $display("[TB] reload     pc=%h inst=%h", pcAddOut, instOut);
        drive(1'b1, 1'b1, 1'b0, 16'h0008, 16'h0001);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0000 || instOut !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL flush_stall: got pc=%h inst=%h, expected pc=0000 inst=0000", pcAddOut, instOut);
        end
        $display("[TB] flush_st   pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_nop_as_data();
        // An instruction equal to the NOP encoding loads like any other data.
        drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0010 || instOut !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL nop_as_data: got pc=%h inst=%h, expected pc=0010 inst=0000", pcAddOut, instOut);
        end
        $display("[TB] nop_data   pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_sync_reset();
        drive(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0003);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0006 || instOut !== 16'h0003) begin
            testsFailed++;
            $display("[TB] FAIL presync_load: got pc=%h inst=%h, expected pc=0006 inst=0003", pcAddOut, instOut);
        end
        drive(1'b0, 1'b0, 1'b1, 16'h0006, 16'h0003);
        #1;
        testsRun++;
        if (pcAddOut !== 16'h0006 || instOut !== 16'h0003) begin
            testsFailed++;
            $display("[TB] FAIL sync_reset_midcycle: got pc=%h inst=%h, expected pc=0006 inst=0003", pcAddOut, instOut);
        end
        $display("[TB] rst_mid    pc=%h inst=%h", pcAddOut, instOut);
        tick();
        testsRun++;
        if (pcAddOut !== 16'h0000 || instOut !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL sync_reset_edge: got pc=%h inst=%h, expected pc=0000 inst=0000", pcAddOut, instOut);
        end
        $display("[TB] rst_edge   pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_recovery();
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE, 16'hFFFF);
        tick();
        testsRun++;
        if (pcAddOut !== 16'hFFFE || instOut !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL recovery: got pc=%h inst=%h, expected pc=fffe inst=ffff", pcAddOut, instOut);
        end
        $display("[TB] recovery   pc=%h inst=%h", pcAddOut, instOut);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pcs   [4];
        logic [WIDTH-1:0] insts [4];
        pcs   = '{16'h0100, 16'h0102, 16'h8000, 16'h7FFF};
        insts = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, pcs[k], insts[k]);
            tick();
            testsRun++;
            if (pcAddOut !== pcs[k] || instOut !== insts[k]) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back%0d: got pc=%h inst=%h, expected pc=%h inst=%h",
                         k, pcAddOut, instOut, pcs[k], insts[k]);
            end
            $display("[TB] b2b%0d       pc=%h inst=%h", k, pcAddOut, instOut);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        IFID_enable = 1'b0;
        pcAddIn     = '0;
        instIn      = '0;
        test_reset();
        test_load();
        test_stall();
        test_input_glitch();
        test_flush();
        test_nop_as_data();
        test_sync_reset();
        test_recovery();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ifid_buffer.md
IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
Parameters:
REQ-001 WIDTH, default 16, bit width of the PC and instruction paths.
REQ-002 FLUSH_INST, default 16'h0000, instruction value loaded on flush or reset (NOP encoding).
REQ-003 FLUSH_PC, default 16'h0000, PC value loaded on flush or reset.

Ports:
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  active-high; squash the IF/ID contents (branch/jump taken).
REQ-007 IFID_enable  input  1  active-high; load new IF stage values (low = stall/hold).
REQ-008 pcAddIn  input  WIDTH  incremented PC from IF stage.
REQ-009 instIn  input  WIDTH  fetched instruction from IF stage.
REQ-010 pcAddOut  output  WIDTH  registered PC to ID stage.
REQ-011 instOut  output  WIDTH  registered instruction to ID stage.

Function
REQ-012 Outputs SHALL be driven directly from internal registers; no combinational path from any input to any output.
REQ-013 The update at each rising clk edge SHALL use strict priority: rst_n low > flush high > IFID_enable high > hold.
REQ-014 rst_n low at an edge: pcAddOut <= FLUSH_PC, instOut <= FLUSH_INST, regardless of flush, IFID_enable and the data inputs.
REQ-015 rst_n high, flush high at an edge: pcAddOut <= FLUSH_PC, instOut <= FLUSH_INST, regardless of IFID_enable (flush overrides stall).
REQ-016 rst_n high, flush low, IFID_enable high at an edge: pcAddOut <= pcAddIn, instOut <= instIn.
REQ-017 rst_n high, flush low, IFID_enable low at an edge: both outputs SHALL hold their previous values.
REQ-018 Latency SHALL be exactly one clk cycle from input capture to output.
REQ-019 Both output registers SHALL always update together; the PC and instruction SHALL never be partially updated.
REQ-020 Input changes between clock edges SHALL have no effect on the outputs.
REQ-021 Only flush and reset SHALL load FLUSH_PC/FLUSH_INST; a loaded instIn that equals FLUSH_INST SHALL be treated as ordinary data.

Reset
REQ-022 Reset SHALL be synchronous and active-low; asserting rst_n between edges SHALL NOT change the outputs until the next rising edge.
REQ-023 After the first rising edge with rst_n low: pcAddOut = FLUSH_PC, instOut = FLUSH_INST.
REQ-024 Before the first reset edge, output values are undefined; the bench SHALL apply reset before checking outputs.
REQ-025 Reset asserted while enable and flush are active SHALL still produce the reset values (REQ-013).

Verification
REQ-026 Reset: rst_n=0, flush=0, IFID_enable=1, pcAddIn=16'h1234, instIn=16'hABCD, one edge -> pcAddOut=16'h0000, instOut=16'h0000.
REQ-027 Load: rst_n=1, flush=0, IFID_enable=1, pcAddIn=16'h0002, instIn=16'h0001 -> after the edge, pcAddOut=16'h0002, instOut=16'h0001; next edge with 16'h0004/16'h0002 -> outputs 16'h0004/16'h0002.
REQ-028 Stall: with outputs at 16'h0004/16'h0002, set IFID_enable=0 and pcAddIn=16'h0006, instIn=16'h0003 for 3 edges -> outputs stay 16'h0004/16'h0002.
REQ-029 Flush overrides: with outputs non-zero, flush=1, IFID_enable=1, pcAddIn=16'h0008, instIn=16'h0001 -> after the edge, outputs 16'h0000/16'h0000; flush=1 with IFID_enable=0 gives the same result.
REQ-030 Sync reset mid-operation: drop rst_n to 0 mid-cycle with outputs at 16'h0006/16'h0003 -> outputs unchanged until the next rising edge, then 16'h0000/16'h0000.
REQ-031 Recovery: release rst_n, then flush=0, IFID_enable=1, pcAddIn=16'hFFFE, instIn=16'hFFFF -> outputs 16'hFFFE/16'hFFFF after one edge (full-width values pass through).
